// File: rtl/xoro_pkg.sv
// Shared types and constants for the xoro memory-bus arbiter.
package xoro_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;
endpackage

// File: rtl/xoro_rr_pick.sv
// Combinational 2-way round-robin selector: on a tie the requester that
// was not granted last wins.
module xoro_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);
  always_comb begin
    grant_valid = |req;
    grant_idx   = req[1];
    if (&req) grant_idx = ~last;
  end
endmodule

// File: rtl/xoro_mem_arbiter.sv
// Two-master round-robin arbiter for the native memory bus, with a
// watchdog that aborts transfers the slave never acknowledges.
module xoro_mem_arbiter
  import xoro_pkg::*;
#(
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        timeout_err
);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic        owner, owner_nx;
  logic        last, last_nx;
  logic [15:0] wdog, wdog_nx;
  bus_req_t    req0, req1, req_own;
  logic        own_valid, grant_valid, grant_idx;
  logic        done_ok, done_to, done;

  assign req0      = {m0_addr, m0_wdata, m0_wstrb};
  assign req1      = {m1_addr, m1_wdata, m1_wstrb};
  assign req_own   = owner ? req1 : req0;
  assign own_valid = owner ? m1_valid : m0_valid;

  xoro_rr_pick u_pick (
    .req         ({m1_valid, m0_valid}),
    .last        (last),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      wdog  <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      wdog  <= wdog_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    wdog_nx  = wdog;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    done_ok  = 1'b0;
    done_to  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          owner_nx = grant_idx;
          last_nx  = grant_idx;
          wdog_nx  = '0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        s_valid = own_valid;
        s_addr  = req_own.addr;
        s_wdata = req_own.wdata;
        s_wstrb = req_own.wstrb;
        // A master withdrawing its request is abandoned silently; a real
        // slave acknowledge beats a watchdog expiry in the same cycle.
        if (!own_valid) begin
          state_nx = IDLE;
        end else if (s_ready) begin
          done_ok  = 1'b1;
          state_nx = DONE;
        end else if (wdog == WD_LAST) begin
          done_to  = 1'b1;
          state_nx = DONE;
        end else begin
          wdog_nx = wdog + 16'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign done        = (done_ok | done_to) & ~reset;
  assign m0_ready    = done & ~owner;
  assign m1_ready    = done & owner;
  assign timeout_err = done_to & ~reset;
  assign m0_rdata    = (done_to && !owner) ? ERR_DATA : s_rdata;
  assign m1_rdata    = (done_to && owner)  ? ERR_DATA : s_rdata;
endmodule

// File: tb/tb_xoro_mem_arbiter.sv
// Scoreboard bench for xoro_mem_arbiter: directed cases then random traffic.
module tb_xoro_mem_arbiter;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ta [2];
  logic [31:0] tw [2];
  logic [3:0]  ts [2];
  logic        pend [2];
  logic        m0_ready, m1_ready, s_valid, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
    int          len;
  } exp_t;
  typedef struct {
    int          d;
    logic [31:0] data;
  } sl_t;

  exp_t sbq[$];
  sl_t  slq[$];
  int   checks = 0, fails = 0, done_cnt = 0, rdy_cyc = 0, cyc = 0, run = 0;
  bit   mlast = 1'b1;

  xoro_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(pend[0]), .m0_addr(ta[0]), .m0_wdata(tw[0]), .m0_wstrb(ts[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(pend[1]), .m1_addr(ta[1]), .m1_wdata(tw[1]), .m1_wstrb(ts[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave model: acknowledges after d waiting cycles of s_valid (d >= TO never acks in time).
  int  scnt = 0;
  sl_t cur;
  always @(negedge clk) begin
    if (s_valid) begin
      if (scnt == 0) begin
        if (slq.size() > 0) cur = slq.pop_front();
        else begin cur.d = 1 << 20; cur.data = '0; end
      end
      s_ready = (scnt == cur.d);
      s_rdata = (scnt == cur.d) ? cur.data : $urandom;
      scnt++;
    end else begin
      scnt    = 0;
      s_ready = 1'b0;
      s_rdata = $urandom;
    end
  end

  // Monitor: compares slave-port fields and every ready pulse against the scoreboard.
  always begin
    exp_t e;
    int   mi;
    @(negedge clk); #2;
    if (reset) run = 0;
    else begin
      run = s_valid ? run + 1 : 0;
      if (s_valid) begin
        if (sbq.size() == 0) chk("unexpected_s_valid", 1, 0);
        else chk("s_fields", {s_addr, s_wdata, s_wstrb}, {sbq[0].addr, sbq[0].wdata, sbq[0].wstrb});
      end
      if (timeout_err && !(m0_ready || m1_ready)) chk("lone_timeout_err", 1, 0);
      if (m0_ready && m1_ready) chk("both_ready", 1, 0);
      else if (m0_ready || m1_ready) begin
        mi = m1_ready ? 1 : 0;
        done_cnt++;
        rdy_cyc = cyc;
        if (sbq.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("ready_master", mi, e.m);
          chk("rdata", mi ? m1_rdata : m0_rdata, e.rdata);
          chk("timeout_err", timeout_err, e.err);
          chk("busy_len", run, e.len);
        end
      end
    end
  end

  task automatic issue(input int m, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    ta[m] = a; tw[m] = w; ts[m] = s; pend[m] = 1'b1;
  endtask

  // Predict the grant from the round-robin rule, queue expectations, await completion.
  task automatic serve(input int d, input logic [31:0] data, output int win);
    exp_t e;
    sl_t  s;
    int   start, k;
    if (pend[0] && pend[1]) win = mlast ? 0 : 1;
    else win = pend[1] ? 1 : 0;
    mlast   = (win == 1);
    e.m     = win;
    e.addr  = ta[win];
    e.wdata = tw[win];
    e.wstrb = ts[win];
    e.err   = (d >= TO);
    e.rdata = e.err ? ERR : data;
    e.len   = e.err ? TO : d + 1;
    s.d = d; s.data = data;
    sbq.push_back(e);
    slq.push_back(s);
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < TO + 10) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == start) begin
      chk("ready_timeout", 0, 1);
      sbq.delete();
      slq.delete();
    end
    #1;
    pend[win] = 1'b0;
  endtask

  initial begin
    int   w, prev, d;
    exp_t e;
    sl_t  s;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; ta[m] = '0; tw[m] = '0; ts[m] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      chk("idle_s_valid", s_valid, 0);
      chk("idle_ready", {m1_ready, m0_ready}, 0);
      chk("idle_timeout_err", timeout_err, 0);
      chk("idle_s_fields", {s_addr, s_wdata, s_wstrb}, 0);
    end
    @(posedge clk); #1;

    // m0 read, two wait states
    issue(0, 32'h0000_0010, 32'h1111_2222, 4'b0000);
    serve(2, 32'h1234_5678, w);

    // m1 write vs. pending m0 with distinct fields
    issue(0, 32'h0000_0400, 32'h5A5A_5A5A, 4'b1111);
    issue(1, 32'h0200_0000, 32'hA5A5_A5A5, 4'b0011);
    serve(1, 32'h0, w);

    // m0 times out while m1 waits, then m1 is served
    issue(1, 32'h0300_0004, 32'h0, 4'b0000);
    serve(TO + 2, 32'h7777_7777, w);
    serve(0, 32'hCAFE_0001, w);

    // ack lands exactly in the watchdog's last cycle
    issue(0, 32'h0000_0020, 32'h0, 4'b0000);
    serve(TO - 1, 32'h0BAD_F00D, w);

    // reset mid-transfer
    issue(0, 32'h0000_0030, 32'h0, 4'b0000);
    e.m = 0; e.addr = ta[0]; e.wdata = tw[0]; e.wstrb = ts[0];
    e.rdata = '0; e.err = 1'b0; e.len = 0;
    sbq.push_back(e);
    s.d = TO + 2; s.data = '0;
    slq.push_back(s);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #2;
    chk("rst_cycle_ready", {m1_ready, m0_ready, timeout_err}, 0);
    @(posedge clk);
    @(negedge clk); #2;
    chk("post_rst_s_valid", s_valid, 0);
    chk("post_rst_ready", {m1_ready, m0_ready}, 0);
    @(posedge clk); #1;
    pend[0] = 1'b0;
    sbq.delete();
    slq.delete();
    mlast = 1'b1;
    reset = 1'b0;

    // continuous requests from both, zero-wait slave: first tie to m0, 3-cycle cadence
    issue(0, $urandom, $urandom, 4'($urandom));
    issue(1, $urandom, $urandom, 4'($urandom));
    for (int i = 0; i < 6; i++) begin
      prev = rdy_cyc;
      serve(0, $urandom, w);
      if (i > 0) chk("rr_spacing", rdy_cyc - prev, 3);
      issue(w, $urandom, $urandom, 4'($urandom));
    end

    for (int r = 0; r < 250; r++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && $urandom_range(0, 1) == 1)
          issue(m, $urandom, $urandom, ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom));
      if (!pend[0] && !pend[1]) begin
        @(posedge clk); #1;
      end else begin
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(0, 2);
        serve(d, $urandom, w);
      end
    end
    while (pend[0] || pend[1]) serve(0, $urandom, w);
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
